muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_div_core.sv | 68 ++++++
 rtl/muldiv_unit.sv | 108 ++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states,
// default divide iteration count and a sign-magnitude helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  localparam int DIV_ITER_DEF = 32;

  // Magnitude of v when it is a negative signed value, otherwise v unchanged.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring unsigned divider: one quotient bit per cycle on magnitudes.
// done is asserted during the last step; quotient/remainder show that step's result.
module div_core
  import muldiv_pkg::*;
#(
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

  logic          active;
  logic [CW-1:0] cnt;
  logic [31:0]   rem, quo, dvs;
  logic [32:0]   rem_sh, diff;
  logic          ge;
  logic [31:0]   rem_nx, quo_nx;

  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = ~diff[32];
    rem_nx = ge ? diff[31:0] : rem_sh[31:0];
    quo_nx = {quo[30:0], ge};
  end

  assign done      = active && (cnt == CW'(DIV_ITER - 1));
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
    end else if (abort) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem    <= '0;
      quo    <= dividend;
      dvs    <= divisor;
    end else if (active) begin
      rem <= rem_nx;
      quo <= quo_nx;
      if (done) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: FSM, operand latching, sign fix-up and HI/LO registers.
// Divide by zero is run through the MUL state with the result write suppressed.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        flush,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  state_e      state, state_nx;
  logic [31:0] a_q, b_q;
  logic        sgn_q, mul_wr_q, neg_q, neg_r;

  logic        accept, is_mul, is_div, sgn_op, b_zero, div_start;
  logic        div_done;
  logic [31:0] div_quo, div_rem;
  logic [63:0] a_ext, b_ext, product;

  assign accept    = op_valid && (state == S_IDLE) && !flush;
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign sgn_op    = (op == OP_MULT) || (op == OP_DIV);
  assign b_zero    = (data_b == 32'd0);
  assign div_start = accept && is_div && !b_zero;

  assign busy      = (state != S_IDLE);
  // MUL is always a final cycle, so only an unfinished divide extends the stall.
  assign stall_req = (accept && (is_mul || is_div)) || ((state == S_DIV) && !div_done);

  assign a_ext   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b_ext   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product = a_ext * b_ext;

  div_core #(.DIV_ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag(data_a, sgn_op)),
    .divisor   (mag(data_b, sgn_op)),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mul)      state_nx = S_MUL;
          else if (accept && is_div) state_nx = b_zero ? S_MUL : S_DIV;
        end
        S_MUL:   state_nx = S_IDLE;
        S_DIV:   if (div_done) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hi       <= '0;
      lo       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      mul_wr_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q      <= data_a;
        b_q      <= data_b;
        sgn_q    <= sgn_op;
        mul_wr_q <= is_mul;
        neg_q    <= sgn_op && (data_a[31] ^ data_b[31]);
        neg_r    <= sgn_op && data_a[31];
        if (op == OP_MTHI) hi <= data_a;
        if (op == OP_MTLO) lo <= data_a;
      end
      if (!flush && (state == S_MUL) && mul_wr_q) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end
      if (!flush && (state == S_DIV) && div_done) begin
        lo <= neg_q ? (~div_quo + 32'd1) : div_quo;
        hi <= neg_r ? (~div_rem + 32'd1) : div_rem;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops against
// an arithmetic reference model; a monitor checks {hi,lo} whenever busy drops.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        flush = 1'b0;
  logic        stall_req, busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.DIV_ITER(ITER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op        (op),
    .data_a    (data_a),
    .data_b    (data_b),
    .flush     (flush),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  int          tests = 0, fails = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        prev_busy = 1'b0;
  logic [63:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {hi,lo} after a MUL/DIV-class op, from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] cur);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return 64'(ua * ub);
      OP_DIV: begin
        if (b == 0) return cur;
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return cur;
        return {a % b, a / b};
      end
      default: return cur;
    endcase
  endfunction

  // Monitor: a completion (or abort) is visible as busy falling.
  always @(negedge clk) begin
    if (prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_completion: hi=%h lo=%h with empty queue", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("hilo", {hi, lo}, mon_e);
      end
    end
    prev_busy = busy;
  end

  // Present an instruction like EX would: hold it while stall_req, present it in the
  // release cycle, then drop it. Optionally swap in an MTHI while the unit is busy.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int exp_stall, input bit intrude);
    int n;
    n = 0;
    @(negedge clk);
    op_valid = 1'b1; op = o; data_a = a; data_b = b;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!stall_req) break;
      n++;
      @(negedge clk);
      if (intrude) begin
        op = OP_MTHI;
        data_a = 32'hDEAD_BEEF;
      end
    end
    check("stall_cycles", 64'(n), 64'(exp_stall));
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit intrude);
    logic [63:0] e;
    int          st;
    st = 0;
    if (o == OP_MULT || o == OP_MULTU) st = 1;
    if (o == OP_DIV || o == OP_DIVU) st = (b == 0) ? 1 : ITER;
    if (st != 0) begin
      e = ref_model(o, a, b, {m_hi, m_lo});
      exp_q.push_back(e);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end else if (o == OP_MTHI) begin
      m_hi = a;
    end else if (o == OP_MTLO) begin
      m_lo = a;
    end
    issue(o, a, b, st, intrude);
  endtask

  // Launch a divide and leave the bench in the negedge of the cycle where counter=k.
  task automatic start_div_to(input logic [31:0] a, input logic [31:0] b, input int k);
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; data_a = a; data_b = b;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    rst_n = 1'b1;

    do_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(OP_DIVU,  32'd100, 32'd7, 1'b1);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(OP_MTHI,  32'h0000_1234, 32'd0, 1'b0);
    do_op(OP_MTLO,  32'h0000_5678, 32'd0, 1'b0);
    do_op(OP_DIV,   32'd5, 32'd0, 1'b0);

    // Flush mid-divide: abandoned, nothing written.
    exp_q.push_back({m_hi, m_lo});
    start_div_to(32'd1000, 32'd3, 10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_stall", 64'(stall_req), 64'd0);

    // Flush blocks acceptance of an MTHI in the same cycle.
    @(negedge clk);
    op_valid = 1'b1; op = OP_MTHI; data_a = 32'h0000_BAD0; flush = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("flush_block_hi", 64'(hi), 64'(m_hi));

    // Reset mid-divide clears HI/LO and abandons the op.
    exp_q.push_back(64'd0);
    start_div_to(32'd77, 32'd5, 20);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    do_op(OP_DIVU, 32'd9, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = pick();
      rb = pick();
      do_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("final_hilo", {hi, lo}, {m_hi, m_lo});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
